// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative cache controller with per-set tree pseudo-LRU and invalid-way preference.
// Define CACHE_CTRL_PERF_EN to add the hit_count / miss_count performance counters.
module cache_ctrl_assoc_plru #(
  parameter int WAYS = 4,
  parameter int WB   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          touch,
  input  logic [WB-1:0] touch_way,
  output logic [WB-1:0] victim_way
);

  logic [WAYS-2:0] tree;

  // Bit value 0 steers toward the lower half; walk from root picking a child per level.
  function automatic logic [WB-1:0] walk(input logic [WAYS-2:0] t);
    int unsigned n;
    walk = '0;
    n    = 0;
    for (int l = 0; l < WB; l++) begin
      walk[WB-1-l] = t[n];
      n = 2*n + 1 + (t[n] ? 1 : 0);
    end
  endfunction

  function automatic logic [WAYS-2:0] point_away(input logic [WAYS-2:0] t, input logic [WB-1:0] w);
    int unsigned n;
    point_away = t;
    n          = 0;
    for (int l = 0; l < WB; l++) begin
      point_away[n] = ~w[WB-1-l];
      n = 2*n + 1 + (w[WB-1-l] ? 1 : 0);
    end
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     tree <= '0;
    else if (touch) tree <= point_away(tree, touch_way);
  end

  assign victim_way = walk(tree);

endmodule

module cache_ctrl_assoc #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [SET_BITS-1:0]   set_idx,
  input  logic [WAYS-1:0]       hit_vec,
  input  logic [WAYS-1:0]       valid_vec,
  input  logic [WAYS-1:0]       dirty_vec,
  input  logic                  pmem_resp,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic                  pmem_addr_sel,
  output logic [$clog2(WAYS)-1:0] way_sel,
  output logic                  load_line,
  output logic                  set_dirty,
  output logic                  clr_dirty
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int WB   = $clog2(WAYS);
  localparam int SETS = 2**SET_BITS;

  typedef enum logic [1:0] {CHECK, WRITE_BACK, ALLOCATE} state_t;

  typedef struct packed {
    logic          mem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic          pmem_addr_sel;
    logic [WB-1:0] way_sel;
    logic          load_line;
    logic          set_dirty;
    logic          clr_dirty;
  } ctl_t;

  state_t                  state_q, state_d;
  ctl_t                    ctl, ctl_o;
  logic [WB-1:0]           victim_q, victim_d;
  logic [SET_BITS-1:0]     miss_set_q;
  logic [SETS-1:0][WB-1:0] plru_way;
  logic                    req, hit_any, inv_any, victim_dirty;
  logic                    hit_touch, fill_touch, miss_take;
  logic [WB-1:0]           hit_way, inv_way, touch_way;

  function automatic logic [WB-1:0] lowest(input logic [WAYS-1:0] v);
    lowest = '0;
    for (int i = WAYS-1; i >= 0; i--)
      if (v[i]) lowest = WB'(i);
  endfunction

  assign req          = mem_read | mem_write;
  assign hit_any      = |hit_vec;
  assign hit_way      = lowest(hit_vec);
  assign inv_any      = ~&valid_vec;
  assign inv_way      = lowest(~valid_vec);
  assign victim_d     = inv_any ? inv_way : plru_way[set_idx];
  assign victim_dirty = valid_vec[victim_d] & dirty_vec[victim_d];
  assign touch_way    = hit_touch ? hit_way : victim_q;

  for (genvar s = 0; s < SETS; s++) begin : g_set
    cache_ctrl_assoc_plru #(.WAYS(WAYS), .WB(WB)) u_plru (
      .clk        (clk),
      .reset      (reset),
      .touch      ((hit_touch  && set_idx    == SET_BITS'(s)) ||
                   (fill_touch && miss_set_q == SET_BITS'(s))),
      .touch_way  (touch_way),
      .victim_way (plru_way[s])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CHECK;
      victim_q   <= '0;
      miss_set_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_take) begin
        victim_q   <= victim_d;
        miss_set_q <= set_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ctl        = '0;
    hit_touch  = 1'b0;
    fill_touch = 1'b0;
    miss_take  = 1'b0;
    case (state_q)
      CHECK: begin
        if (req && hit_any) begin
          ctl.mem_resp  = 1'b1;
          ctl.way_sel   = hit_way;
          ctl.set_dirty = mem_write;
          hit_touch     = 1'b1;
        end else if (req) begin
          miss_take = 1'b1;
          state_d   = victim_dirty ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        ctl.pmem_write    = 1'b1;
        ctl.pmem_addr_sel = 1'b1;
        ctl.way_sel       = victim_q;
        if (pmem_resp) begin
          ctl.clr_dirty = 1'b1;
          state_d       = req ? ALLOCATE : CHECK;
        end
      end
      ALLOCATE: begin
        // A dropped request still installs the line once memory answers.
        ctl.pmem_read = 1'b1;
        ctl.way_sel   = victim_q;
        if (pmem_resp) begin
          ctl.load_line = 1'b1;
          ctl.clr_dirty = 1'b1;
          fill_touch    = 1'b1;
          state_d       = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  // Outputs fall to zero the moment reset asserts, without waiting for a clock.
  assign ctl_o         = reset ? ctl : '0;
  assign mem_resp      = ctl_o.mem_resp;
  assign pmem_read     = ctl_o.pmem_read;
  assign pmem_write    = ctl_o.pmem_write;
  assign pmem_addr_sel = ctl_o.pmem_addr_sel;
  assign way_sel       = ctl_o.way_sel;
  assign load_line     = ctl_o.load_line;
  assign set_dirty     = ctl_o.set_dirty;
  assign clr_dirty     = ctl_o.clr_dirty;

`ifdef CACHE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_touch) hit_count  <= hit_count + 32'd1;
      if (miss_take) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Bench for cache_ctrl_assoc: transaction-level reference model checked every negedge plus directed literals.
module tb_cache_ctrl_assoc;
  localparam int WAYS = 4, SET_BITS = 3, SETS = 8, WB = 2;

  logic clk = 1'b0, reset = 1'b0;
  logic mem_read = 0, mem_write = 0, pmem_resp = 0;
  logic [SET_BITS-1:0] set_idx = '0;
  logic [WAYS-1:0] hit_vec = '0, valid_vec = '0, dirty_vec = '0;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_line, set_dirty, clr_dirty;
  logic [WB-1:0] way_sel;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  cache_ctrl_assoc #(.WAYS(WAYS), .SET_BITS(SET_BITS)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
    .load_line(load_line), .set_dirty(set_dirty), .clr_dirty(clr_dirty)
`ifdef CACHE_CTRL_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 waiting for requests, 1 writing a victim back, 2 filling the victim
  int m_phase = 0, m_vict = 0, m_set = 0;
  bit m_ptr_upper [SETS][WAYS-1];
  logic [31:0] m_hits = 0, m_miss = 0;

  function automatic int first_one(input logic [WAYS-1:0] v);
    for (int i = 0; i < WAYS; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Tree nodes by level: node covering range starting at lo (span WAYS>>l) is (2^l-1) + lo/span.
  function automatic int m_victim(input int s);
    int lo = 0, half = WAYS;
    for (int l = 0; l < WB; l++) begin
      int node;
      node = (1 << l) - 1 + lo / half;
      half = half / 2;
      if (m_ptr_upper[s][node]) lo += half;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int lo = 0, half = WAYS;
    for (int l = 0; l < WB; l++) begin
      int node;
      node = (1 << l) - 1 + lo / half;
      half = half / 2;
      if (w >= lo + half) begin m_ptr_upper[s][node] = 1'b0; lo += half; end
      else m_ptr_upper[s][node] = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_phase = 0; m_vict = 0; m_set = 0; m_hits = 0; m_miss = 0;
        for (int s = 0; s < SETS; s++) for (int n = 0; n < WAYS-1; n++) m_ptr_upper[s][n] = 1'b0;
        chk("reset_outputs", {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
                              load_line, set_dirty, clr_dirty}, 64'd0);
      end else begin
        logic e_resp, e_pr, e_pw, e_sel, e_ll, e_sd, e_cd;
        logic [WB-1:0] e_way;
        logic req;
        logic [WAYS-1:0] inv;
        int v;
        req = mem_read | mem_write;
        {e_resp, e_pr, e_pw, e_sel, e_ll, e_sd, e_cd} = '0;
        e_way = '0;
        case (m_phase)
          0: if (req && hit_vec != 0) begin
               e_resp = 1; e_way = WB'(first_one(hit_vec)); e_sd = mem_write;
             end
          1: begin e_pw = 1; e_sel = 1; e_way = WB'(m_vict); e_cd = pmem_resp; end
          default: begin e_pr = 1; e_way = WB'(m_vict); e_ll = pmem_resp; e_cd = pmem_resp; end
        endcase
        chk("outputs", {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
                        load_line, set_dirty, clr_dirty},
                       {e_resp, e_pr, e_pw, e_sel, e_way, e_ll, e_sd, e_cd});
        chk("strobe_exclusive", pmem_read & pmem_write, 64'd0);
`ifdef CACHE_CTRL_PERF_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_miss);
`endif
        // advance the model to what the next rising edge must produce
        case (m_phase)
          0: if (req) begin
               if (hit_vec != 0) begin
                 m_touch(set_idx, first_one(hit_vec)); m_hits++;
               end else begin
                 inv = ~valid_vec;
                 v = (inv != 0) ? first_one(inv) : m_victim(set_idx);
                 m_vict = v; m_set = set_idx; m_miss++;
                 m_phase = (valid_vec[v] && dirty_vec[v]) ? 1 : 2;
               end
             end
          1: if (pmem_resp) m_phase = req ? 2 : 0;
          default: if (pmem_resp) begin m_touch(m_set, m_vict); m_phase = 0; end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read = 0; mem_write = 0; hit_vec = '0; pmem_resp = 0;
  endtask

  initial begin
    // reset held 3 cycles with a would-be hit on the inputs: outputs must stay 0
    mem_read = 1; set_idx = 3'd2; hit_vec = 4'b0001; valid_vec = 4'b1111;
    step(3);
    chk("reset_gates_resp", mem_resp, 64'd0);
    idle();
    reset = 1;
    step();

    // 1: hit on way 2 of set 2, zero latency
    mem_read = 1; set_idx = 3'd2; hit_vec = 4'b0100; valid_vec = 4'b1111; #1;
    chk("t1_hit_resp", mem_resp, 64'd1);
    chk("t1_hit_way", way_sel, 64'd2);
    step(); idle(); step();

    // 2: clean miss in set 1, invalid way 2 chosen, fill after 5 cycles
    mem_read = 1; set_idx = 3'd1; valid_vec = 4'b1011; dirty_vec = 4'b0000; #1;
    chk("t2_miss_no_resp", mem_resp, 64'd0);
    step();
    chk("t2_alloc_read", pmem_read, 64'd1);
    chk("t2_alloc_way", way_sel, 64'd2);
    chk("t2_alloc_addrsel", pmem_addr_sel, 64'd0);
    for (int i = 0; i < 4; i++) begin step(); chk("t2_read_held", pmem_read, 64'd1); end
    step(); pmem_resp = 1; #1;
    chk("t2_load_line", load_line, 64'd1);
    step(); pmem_resp = 0; hit_vec = 4'b0100; valid_vec = 4'b1111; #1;
    chk("t2_post_fill_resp", mem_resp, 64'd1);
    step(); idle(); step();

    // 3: set 5, hits 0..3 then dirty miss -> victim way 0 via PLRU
    mem_read = 1; set_idx = 3'd5; valid_vec = 4'b1111; dirty_vec = 4'b0000;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec = '0; hit_vec[w] = 1'b1; step();
    end
    hit_vec = '0; dirty_vec = 4'b0001;
    step();
    chk("t3_wb_write", pmem_write, 64'd1);
    chk("t3_wb_addrsel", pmem_addr_sel, 64'd1);
    chk("t3_victim_way", way_sel, 64'd0);
    step(); pmem_resp = 1; #1;
    chk("t3_clr_dirty", clr_dirty, 64'd1);
    step(); pmem_resp = 0;
    chk("t3_alloc_read", pmem_read, 64'd1);
    chk("t3_alloc_way", way_sel, 64'd0);
    step(); pmem_resp = 1; step(); pmem_resp = 0; hit_vec = 4'b0001; #1;
    chk("t3_final_resp", mem_resp, 64'd1);
    step(); idle(); step();

    // 4: dirty write miss in set 3, request dropped 2 cycles into WRITE_BACK
    mem_write = 1; set_idx = 3'd3; valid_vec = 4'b1111; dirty_vec = 4'b1111;
    step(2);
    mem_write = 0;
    step(2);
    chk("t4_write_held", pmem_write, 64'd1);
    pmem_resp = 1; step(); pmem_resp = 0;
    chk("t4_no_read", pmem_read, 64'd0);
    chk("t4_back_idle", pmem_write, 64'd0);
    step();
    chk("t4_still_no_read", pmem_read, 64'd0);

    // 5: reset in ALLOCATE of set 6 (invalid way 3)
    mem_read = 1; set_idx = 3'd6; valid_vec = 4'b0111; dirty_vec = 4'b0000;
    step(2);
    chk("t5_alloc_way", way_sel, 64'd3);
    reset = 0; #1;
    chk("t5_async_drop", pmem_read, 64'd0);
    idle(); step(2); reset = 1; step();

    // 6: 3 hits in set 0, then clean miss in set 5: cleared PLRU picks way 0 (pre-reset tree would give 2)
    mem_read = 1; set_idx = 3'd0; valid_vec = 4'b1111; dirty_vec = 4'b0000;
    hit_vec = 4'b0001; step(); hit_vec = 4'b0010; step(); hit_vec = 4'b0100; step();
    hit_vec = '0; set_idx = 3'd5;
    step();
    chk("t6_plru_cleared_way", way_sel, 64'd0);
    pmem_resp = 1; step(); pmem_resp = 0; hit_vec = 4'b0001; #1;
    chk("t6_fill_resp", mem_resp, 64'd1);
    step(); idle(); step();
`ifdef CACHE_CTRL_PERF_EN
    chk("t6_hit_count", hit_count, 64'd4);
    chk("t6_miss_count", miss_count, 64'd1);
`endif
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
